// File: rtl/demux_i32_o320_pkg.sv
// demux_i32_o320_pkg: framing constants shared by the 320->32 serializer and the 32->320 demux
// Holds the default word width and frame length, the frame counter width, and the
// state encodings of both ends of the FIFO link so they agree on framing.
package demux_i32_o320_pkg;
    localparam int BATCHSIZE   = 32;
    localparam int BATCHNUM    = 10;
    localparam int FRAME_CNT_W = 16;
    typedef enum logic {FILL = 1'b0, PRESENT = 1'b1} demux_state_e;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MUX = 2'd2} ser_state_e;
endpackage

// File: rtl/demux_i32_o320.sv
// demux_i32_o320: reassembles batchnum-word frames popped from a standard (non-FWFT) FIFO
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   FIFO_DOUT, FIFO_EMPTY FIFO read data (valid the cycle after FIFO_RD) and empty flag
//   FIFO_RD               combinational FIFO read enable
//   DATAOUT, DATA_READY   registered frame (word 0 in the low slice) and its valid level
//   DATA_ACK              consumer has taken the frame
//   FRAME_CNT             frames delivered since reset, wrapping
module demux_i32_o320
    import demux_i32_o320_pkg::*;
#(
    parameter int batchsize = BATCHSIZE,
    parameter int batchnum  = BATCHNUM,
    parameter int CNTW      = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [batchsize-1:0]          FIFO_DOUT,
    input  logic                          FIFO_EMPTY,
    output logic                          FIFO_RD,
    output logic [batchnum*batchsize-1:0] DATAOUT,
    output logic                          DATA_READY,
    input  logic                          DATA_ACK,
    output logic [FRAME_CNT_W-1:0]        FRAME_CNT
);
    demux_state_e state;
    logic [CNTW-1:0] rd_cnt;
    logic [CNTW-1:0] wr_cnt;
    logic rd_pending;
    // The top slice never lives here: the final word goes straight into DATAOUT.
    logic [(batchnum-1)*batchsize-1:0] buffer;
    logic last_word;

    assign FIFO_RD   = (state == FILL) && !FIFO_EMPTY && (rd_cnt < CNTW'(batchnum));
    assign last_word = rd_pending && (wr_cnt == CNTW'(batchnum - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= FILL;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_pending <= 1'b0;
            buffer     <= '0;
            DATAOUT    <= '0;
            DATA_READY <= 1'b0;
            FRAME_CNT  <= '0;
        end else begin
            rd_pending <= FIFO_RD;
            if (FIFO_RD)
                rd_cnt <= rd_cnt + 1'b1;
            if (last_word) begin
                DATAOUT    <= {FIFO_DOUT, buffer};
                DATA_READY <= 1'b1;
                FRAME_CNT  <= FRAME_CNT + 1'b1;
                rd_cnt     <= '0;
                wr_cnt     <= '0;
                state      <= PRESENT;
            end else if (rd_pending) begin
                buffer[wr_cnt*batchsize +: batchsize] <= FIFO_DOUT;
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (state == PRESENT && DATA_ACK) begin
                DATA_READY <= 1'b0;
                state      <= FILL;
            end
        end
    end
endmodule

// File: tb/tb_demux_i32_o320.sv
// tb_demux_i32_o320: directed and loopback checks of the frame reassembler against a FIFO model and scoreboard
module tb_demux_i32_o320;
    import demux_i32_o320_pkg::*;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [31:0]  FIFO_DOUT = '0;
    logic         FIFO_EMPTY = 1'b1;
    logic         FIFO_RD;
    logic [319:0] DATAOUT;
    logic         DATA_READY;
    logic         DATA_ACK = 1'b0;
    logic [15:0]  FRAME_CNT;

    always #5 CLK = ~CLK;

    demux_i32_o320 dut (
        .CLK(CLK), .RST_N(RST_N), .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RD(FIFO_RD), .DATAOUT(DATAOUT), .DATA_READY(DATA_READY),
        .DATA_ACK(DATA_ACK), .FRAME_CNT(FRAME_CNT)
    );

    logic [31:0]  fq[$];
    logic [319:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int first_rd = -1;
    int rise_cyc = -1;
    int rises = 0;
    int ready_len = 0;
    int last_len = 0;
    int tgt;
    logic prev_ready = 1'b0;
    logic rd_s;
    logic stall = 1'b0;
    logic [319:0] f;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [319:0] mk(input logic [31:0] base);
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic push_frame(input logic [319:0] fr);
        for (int i = 0; i < 10; i++) fq.push_back(fr[i*32 +: 32]);
        exp_q.push_back(fr);
        FIFO_EMPTY = stall;
    endtask

    // One clock: monitor at the falling edge, then advance the FIFO model just after the rising edge.
    task automatic tick();
        @(negedge CLK);
        if (FIFO_RD) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        check("rd_while_empty", 320'(FIFO_RD && FIFO_EMPTY), 320'(0));
        check("rd_while_present", 320'(FIFO_RD && DATA_READY), 320'(0));
        if (DATA_READY && !prev_ready) begin
            rise_cyc = cyc;
            rises++;
            check("frame_expected", 320'(exp_q.size() != 0), 320'(1));
            if (exp_q.size() != 0) check("frame", DATAOUT, exp_q.pop_front());
        end
        if (!DATA_READY && prev_ready) last_len = ready_len;
        ready_len = DATA_READY ? ready_len + 1 : 0;
        prev_ready = DATA_READY;
        rd_s = FIFO_RD;
        @(posedge CLK);
        #1;
        cyc++;
        if (rd_s && fq.size() != 0) FIFO_DOUT = fq.pop_front();
        FIFO_EMPTY = stall || fq.size() == 0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && rises < target; i++) tick();
        check("frame_timeout", 320'(rises), 320'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_dataout", DATAOUT, 320'(0));
        check("rst_ready", 320'(DATA_READY), 320'(0));
        check("rst_frame_cnt", 320'(FRAME_CNT), 320'(0));
        check("rst_rd", 320'(FIFO_RD), 320'(0));
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // single best-case frame
        DATA_ACK = 1'b1;
        rd_pulses = 0;
        first_rd = -1;
        push_frame(mk(32'h0));
        wait_frames(1, 40);
        check("best_latency", 320'(rise_cyc - first_rd), 320'(11));
        check("word0", 320'(DATAOUT[31:0]), 320'(0));
        check("word9", 320'(DATAOUT[319:288]), 320'(9));
        check("frame_cnt_1", 320'(FRAME_CNT), 320'(1));
        repeat (4) tick();
        check("rd_pulses_10", 320'(rd_pulses), 320'(10));
        check("ready_len_1", 320'(last_len), 320'(1));

        // five-cycle empty stall after word 3
        rd_pulses = 0;
        first_rd = -1;
        push_frame(mk(32'h0));
        for (int i = 0; i < 40 && fq.size() > 6; i++) tick();
        stall = 1'b1;
        FIFO_EMPTY = 1'b1;
        repeat (5) tick();
        check("stall_rd_pulses", 320'(rd_pulses), 320'(4));
        stall = 1'b0;
        FIFO_EMPTY = fq.size() == 0;
        wait_frames(2, 60);
        check("stall_latency", 320'(rise_cyc - first_rd), 320'(16));
        check("frame_cnt_2", 320'(FRAME_CNT), 320'(2));

        // backpressure with two frames queued
        DATA_ACK = 1'b0;
        push_frame(mk(32'h100));
        push_frame(mk(32'h200));
        wait_frames(3, 40);
        rd_pulses = 0;
        repeat (20) begin
            tick();
            check("hold_data", DATAOUT, mk(32'h100));
            check("hold_ready", 320'(DATA_READY), 320'(1));
        end
        check("hold_no_rd", 320'(rd_pulses), 320'(0));
        check("hold_no_second", 320'(rises), 320'(3));
        DATA_ACK = 1'b1;
        wait_frames(4, 40);
        check("frame_cnt_4", 320'(FRAME_CNT), 320'(4));

        // reset mid-frame after four popped words
        for (int i = 0; i < 4; i++) fq.push_back(32'hDEAD0000 + 32'(i));
        FIFO_EMPTY = 1'b0;
        for (int i = 0; i < 20 && fq.size() != 0; i++) tick();
        tick();
        RST_N = 1'b0;
        #1;
        check("mid_rst_dataout", DATAOUT, 320'(0));
        check("mid_rst_ready", 320'(DATA_READY), 320'(0));
        check("mid_rst_frame_cnt", 320'(FRAME_CNT), 320'(0));
        check("mid_rst_rd", 320'(FIFO_RD), 320'(0));
        exp_q.delete();
        repeat (2) tick();
        RST_N = 1'b1;
        tgt = rises + 1;
        push_frame(mk(32'h500));
        wait_frames(tgt, 40);
        check("after_rst_cnt", 320'(FRAME_CNT), 320'(1));

        // loopback of 100 random frames with random acknowledge
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        exp_q.delete();
        fq.delete();
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 10; i++) f[i*32 +: 32] = $urandom;
            push_frame(f);
        end
        tgt = rises + 100;
        for (int i = 0; i < 6000 && rises < tgt; i++) begin
            DATA_ACK = 1'($urandom_range(0, 1));
            tick();
        end
        check("loop_frames", 320'(rises), 320'(tgt));
        check("loop_frame_cnt", 320'(FRAME_CNT), 320'(100));
        DATA_ACK = 1'b1;
        repeat (3) tick();

        // counter wrap from 65535
        force dut.FRAME_CNT = 16'hFFFF;
        tick();
        release dut.FRAME_CNT;
        tick();
        tgt = rises + 1;
        push_frame(mk(32'h900));
        wait_frames(tgt, 40);
        check("wrap_cnt", 320'(FRAME_CNT), 320'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
